// File: rtl/wfg_drive_pdm.sv
// wfg_drive_pdm
//   AXI-Stream sink that turns 18-bit signed samples into a 1-bit
//   pulse-density stream with a first-order sigma-delta modulator.
//   Samples enter a one-entry prefetch buffer, are converted to offset
//   binary, and each sample is held for osr_eff modulator bits. The bit
//   period is (clkcfg_div_q_i + 1) clk cycles.
//
// Ports
//   clk                     clock
//   rst_n                   asynchronous active-low reset
//   wfg_drive_pdm_tready_o  AXI-Stream ready (enable and buffer empty)
//   wfg_drive_pdm_tvalid_i  AXI-Stream valid
//   wfg_drive_pdm_tdata_i   AXI-Stream signed sample
//   ctrl_en_q_i             block enable; low forces IDLE and clears state
//   clkcfg_div_q_i          bit period minus 1, in clk cycles
//   osr_q_i                 PDM bits per sample, 0 behaves as 1
//   pdm_o                   registered PDM bit
//   active_o                high while in RUN
//   underrun_o              one-cycle pulse when a sample boundary finds
//                           the buffer empty (current sample is repeated)
module wfg_drive_pdm #(
  parameter int unsigned DIVW = 16,
  parameter int unsigned OSRW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               wfg_drive_pdm_tready_o,
  input  logic               wfg_drive_pdm_tvalid_i,
  input  logic signed [17:0] wfg_drive_pdm_tdata_i,
  input  logic               ctrl_en_q_i,
  input  logic [DIVW-1:0]    clkcfg_div_q_i,
  input  logic [OSRW-1:0]    osr_q_i,
  output logic               pdm_o,
  output logic               active_o,
  output logic               underrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  state_t            state_q;
  logic              buf_full_q;
  logic [17:0]       buf_q;
  logic [17:0]       sample_q;
  logic [17:0]       acc_q;
  logic [DIVW-1:0]   div_cnt_q;
  logic [OSRW-1:0]   bit_cnt_q;

  logic              hs;
  logic              tick;
  logic              boundary;
  logic [OSRW-1:0]   osr_last;
  logic [18:0]       sum;

  // Flipping the sign bit adds 2^17, mapping the signed range onto
  // 0 .. 2^18-1 so the accumulator carry gives the ones density directly.
  function automatic logic [17:0] to_offset(input logic signed [17:0] s);
    return {~s[17], s[16:0]};
  endfunction

  // One modulator step: bit 18 is the PDM output, bits 17:0 the new acc.
  function automatic logic [18:0] sd_step(input logic [17:0] acc,
                                          input logic [17:0] smp);
    return {1'b0, acc} + {1'b0, smp};
  endfunction

  assign wfg_drive_pdm_tready_o = ctrl_en_q_i & ~buf_full_q;
  assign hs       = wfg_drive_pdm_tvalid_i & wfg_drive_pdm_tready_o;
  assign osr_last = (osr_q_i == '0) ? '0 : osr_q_i - OSRW'(1);

  // ">=" rather than "==" so lowering a limit mid-run never lets a
  // counter run past it and wrap.
  assign tick     = (div_cnt_q >= clkcfg_div_q_i);
  assign boundary = tick & (bit_cnt_q >= osr_last);
  assign sum      = sd_step(acc_q, sample_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      sample_q   <= '0;
      acc_q      <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pdm_o      <= 1'b0;
      active_o   <= 1'b0;
      underrun_o <= 1'b0;
    end else if (!ctrl_en_q_i) begin
      // Disable flushes everything, including any buffered sample.
      state_q    <= ST_IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      sample_q   <= '0;
      acc_q      <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pdm_o      <= 1'b0;
      active_o   <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;

      // Capture and consume never collide: capture needs the buffer empty,
      // consume needs it full.
      if (hs) begin
        buf_q      <= to_offset(wfg_drive_pdm_tdata_i);
        buf_full_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (buf_full_q) begin
            sample_q   <= buf_q;
            buf_full_q <= 1'b0;
            acc_q      <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            state_q    <= ST_RUN;
            active_o   <= 1'b1;
          end
        end

        ST_RUN: begin
          if (tick) begin
            div_cnt_q <= '0;
            pdm_o     <= sum[18];
            acc_q     <= sum[17:0];
            if (boundary) begin
              bit_cnt_q <= '0;
              if (buf_full_q) begin
                sample_q   <= buf_q;
                buf_full_q <= 1'b0;
              end else begin
                // Starved: keep modulating the current sample.
                underrun_o <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + OSRW'(1);
            end
          end else begin
            div_cnt_q <= div_cnt_q + DIVW'(1);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wfg_drive_pdm.sv
`timescale 1ns/1ps
module tb_wfg_drive_pdm;
  localparam int DIVW  = 16;
  localparam int OSRW  = 8;
  localparam int LIMIT = 60;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            tready;
  logic            tvalid;
  logic [17:0]     tdata;
  logic            en;
  logic [DIVW-1:0] div;
  logic [OSRW-1:0] osr;
  logic            pdm;
  logic            active;
  logic            underrun;

  wfg_drive_pdm #(.DIVW(DIVW), .OSRW(OSRW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .wfg_drive_pdm_tready_o (tready),
    .wfg_drive_pdm_tvalid_i (tvalid),
    .wfg_drive_pdm_tdata_i  (tdata),
    .ctrl_en_q_i            (en),
    .clkcfg_div_q_i         (div),
    .osr_q_i                (osr),
    .pdm_o                  (pdm),
    .active_o               (active),
    .underrun_o             (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int   cyc;
    logic pdm;
    logic und;
  } exp_t;
  exp_t        exp_q[$];
  int unsigned m_acc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned offset_of(input logic [17:0] smp);
    int v;
    int unsigned r;
    v = int'($signed(smp));
    r = v + 131072;
    return r;
  endfunction

  // Ideal first-order modulator: ones density = u / 2^18.
  function automatic logic model_tick(input int unsigned u);
    int unsigned s;
    s = m_acc + u;
    m_acc = s % 262144;
    return (s >= 262144);
  endfunction

  task automatic push_bits(input int first_cyc, input int stride, input logic [17:0] smp,
                           input int n, input int osr_eff, input bit und_on_boundary);
    exp_t e;
    int unsigned u;
    u = offset_of(smp);
    for (int j = 0; j < n; j++) begin
      e.cyc = first_cyc + j * stride;
      e.pdm = model_tick(u);
      e.und = und_on_boundary && ((j % osr_eff) == osr_eff - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic go_idle();
    en     = 1'b0;
    tvalid = 1'b0;
    step();
    step();
    m_acc = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    tvalid = 1'b0;
    tdata  = '0;
    div    = '0;
    osr    = '0;
    step();
    step();
    n_checks++; if (pdm !== 1'b0)      $display("FAIL reset_pdm got=%b exp=0", pdm); else n_pass++;
    n_checks++; if (active !== 1'b0)   $display("FAIL reset_active got=%b exp=0", active); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got=%b exp=0", underrun); else n_pass++;
    n_checks++; if (tready !== 1'b0)   $display("FAIL reset_tready got=%b exp=0", tready); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_disabled();
    tvalid = 1'b1;
    tdata  = 18'h00123;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (tready !== 1'b0) $display("FAIL dis_tready cyc=%0d got=%b exp=0", cyc, tready); else n_pass++;
      n_checks++; if (pdm !== 1'b0)    $display("FAIL dis_pdm cyc=%0d got=%b exp=0", cyc, pdm); else n_pass++;
      n_checks++; if (active !== 1'b0) $display("FAIL dis_active cyc=%0d got=%b exp=0", cyc, active); else n_pass++;
      step();
    end
    tvalid = 1'b0;
    en     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (tready !== 1'b1) $display("FAIL dis_nocapture_tready cyc=%0d got=%b exp=1", cyc, tready); else n_pass++;
      n_checks++; if (active !== 1'b0) $display("FAIL dis_nocapture_active cyc=%0d got=%b exp=0", cyc, active); else n_pass++;
    end
  endtask

  task automatic test_alternate();
    exp_t e;
    logic cur_pdm, cur_und;
    int   hs;
    go_idle();
    div = 16'd0;
    osr = 8'd4;
    en  = 1'b1;
    step();
    tvalid = 1'b1;
    tdata  = 18'h00000;
    n_checks++; if (tready !== 1'b1) $display("FAIL alt_tready got=%b exp=1", tready); else n_pass++;
    hs = cyc;
    push_bits(hs + 3, 1, 18'h00000, 8, 4, 1'b1);
    step();
    tvalid  = 1'b0;
    cur_pdm = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); cur_pdm = e.pdm; cur_und = e.und;
      end else cur_und = 1'b0;
      n_checks++; if (pdm !== cur_pdm)      $display("FAIL alt_pdm cyc=%0d got=%b exp=%b", cyc - hs, pdm, cur_pdm); else n_pass++;
      n_checks++; if (underrun !== cur_und) $display("FAIL alt_underrun cyc=%0d got=%b exp=%b", cyc - hs, underrun, cur_und); else n_pass++;
      if (cyc == hs + 1) begin
        n_checks++; if (active !== 1'b0) $display("FAIL alt_active_early got=%b exp=0", active); else n_pass++;
      end
      if (cyc == hs + 2) begin
        n_checks++; if (active !== 1'b1) $display("FAIL alt_active_run got=%b exp=1", active); else n_pass++;
      end
      if (exp_q.size() == 0) break;
      step();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL alt_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stream();
    exp_t        e;
    logic        cur_pdm, cur_und;
    logic [17:0] smp [4];
    int          hs [4];
    int          idx;
    go_idle();
    smp[0] = 18'h10000; smp[1] = 18'h20000; smp[2] = 18'h00000; smp[3] = 18'h10000;
    for (int i = 0; i < 4; i++) hs[i] = -1000;
    div = 16'd0;
    osr = 8'd4;
    en  = 1'b1;
    step();
    idx     = 0;
    cur_pdm = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); cur_pdm = e.pdm; cur_und = e.und;
      end else cur_und = 1'b0;
      n_checks++; if (pdm !== cur_pdm)      $display("FAIL stream_pdm cyc=%0d got=%b exp=%b", cyc, pdm, cur_pdm); else n_pass++;
      n_checks++; if (underrun !== cur_und) $display("FAIL stream_underrun cyc=%0d got=%b exp=%b", cyc, underrun, cur_und); else n_pass++;
      if (idx > 0 && cyc == hs[0] + 3) begin
        n_checks++; if (tready !== 1'b0) $display("FAIL stream_tready_full got=%b exp=0", tready); else n_pass++;
      end
      if (idx < 4) begin
        tvalid = 1'b1;
        tdata  = smp[idx];
        if (tready === 1'b1) begin
          hs[idx] = cyc;
          push_bits(hs[0] + 3 + 4 * idx, 1, smp[idx], 4, 4, idx == 3);
          idx++;
        end
      end else tvalid = 1'b0;
      if (idx == 4 && exp_q.size() == 0) break;
      step();
    end
    tvalid = 1'b0;
    n_checks++; if (exp_q.size() != 0 || idx != 4) $display("FAIL stream_timeout sent=%0d left=%0d exp=4/0", idx, exp_q.size()); else n_pass++;
    n_checks++; if (hs[1] - hs[0] != 2) $display("FAIL stream_gap01 got=%0d exp=2", hs[1] - hs[0]); else n_pass++;
    n_checks++; if (hs[2] - hs[1] != 4) $display("FAIL stream_gap12 got=%0d exp=4", hs[2] - hs[1]); else n_pass++;
    n_checks++; if (hs[3] - hs[2] != 4) $display("FAIL stream_gap23 got=%0d exp=4", hs[3] - hs[2]); else n_pass++;
  endtask

  task automatic test_divider();
    exp_t        e;
    logic        cur_pdm, cur_und;
    logic [17:0] smp [3];
    int          hs [3];
    int          idx;
    go_idle();
    smp[0] = 18'h00000; smp[1] = 18'h20000; smp[2] = 18'h1FFFF;
    for (int i = 0; i < 3; i++) hs[i] = -1000;
    div = 16'd3;
    osr = 8'd2;
    en  = 1'b1;
    step();
    idx     = 0;
    cur_pdm = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); cur_pdm = e.pdm; cur_und = e.und;
      end else cur_und = 1'b0;
      n_checks++; if (pdm !== cur_pdm)      $display("FAIL div_pdm cyc=%0d got=%b exp=%b", cyc, pdm, cur_pdm); else n_pass++;
      n_checks++; if (underrun !== cur_und) $display("FAIL div_underrun cyc=%0d got=%b exp=%b", cyc, underrun, cur_und); else n_pass++;
      if (idx < 3) begin
        tvalid = 1'b1;
        tdata  = smp[idx];
        if (tready === 1'b1) begin
          hs[idx] = cyc;
          push_bits(hs[0] + 6 + 8 * idx, 4, smp[idx], 2, 2, idx == 2);
          idx++;
        end
      end else tvalid = 1'b0;
      if (idx == 3 && exp_q.size() == 0) break;
      step();
    end
    tvalid = 1'b0;
    n_checks++; if (exp_q.size() != 0 || idx != 3) $display("FAIL div_timeout sent=%0d left=%0d exp=3/0", idx, exp_q.size()); else n_pass++;
    n_checks++; if (hs[1] - hs[0] != 2) $display("FAIL div_gap01 got=%0d exp=2", hs[1] - hs[0]); else n_pass++;
    n_checks++; if (hs[2] - hs[1] != 8) $display("FAIL div_gap12 got=%0d exp=8", hs[2] - hs[1]); else n_pass++;
  endtask

  task automatic test_underrun();
    exp_t e;
    logic cur_pdm, cur_und;
    int   hs;
    int   ones;
    go_idle();
    div = 16'd0;
    osr = 8'd1;
    en  = 1'b1;
    step();
    tvalid = 1'b1;
    tdata  = 18'h1FFFF;
    n_checks++; if (tready !== 1'b1) $display("FAIL und_tready got=%b exp=1", tready); else n_pass++;
    hs = cyc;
    push_bits(hs + 3, 1, 18'h1FFFF, 10, 1, 1'b1);
    step();
    tvalid  = 1'b0;
    cur_pdm = 1'b0;
    ones    = 0;
    for (int k = 0; k < LIMIT; k++) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); cur_pdm = e.pdm; cur_und = e.und;
        if (pdm === 1'b1) ones++;
      end else cur_und = 1'b0;
      n_checks++; if (pdm !== cur_pdm)      $display("FAIL und_pdm cyc=%0d got=%b exp=%b", cyc - hs, pdm, cur_pdm); else n_pass++;
      n_checks++; if (underrun !== cur_und) $display("FAIL und_pulse cyc=%0d got=%b exp=%b", cyc - hs, underrun, cur_und); else n_pass++;
      if (exp_q.size() == 0) break;
      step();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL und_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
    n_checks++; if (ones != 9) $display("FAIL und_ones got=%0d exp=9", ones); else n_pass++;
  endtask

  task automatic test_disable_midrun();
    exp_t e;
    logic cur_pdm, cur_und;
    int   c0;
    int   hs;
    go_idle();
    div = 16'd0;
    osr = 8'd4;
    en  = 1'b1;
    step();
    tvalid = 1'b1;
    tdata  = 18'h00000;
    c0 = cyc;
    step();
    tvalid = 1'b0;
    step();
    tvalid = 1'b1;
    tdata  = 18'h10000;
    n_checks++; if (tready !== 1'b1) $display("FAIL dmr_tready_second got=%b exp=1", tready); else n_pass++;
    step();
    tvalid = 1'b0;
    n_checks++; if (tready !== 1'b0) $display("FAIL dmr_tready_full got=%b exp=0", tready); else n_pass++;
    n_checks++; if (active !== 1'b1) $display("FAIL dmr_active_run got=%b exp=1", active); else n_pass++;
    en = 1'b0;
    #1;
    n_checks++; if (tready !== 1'b0) $display("FAIL dmr_tready_drop got=%b exp=0", tready); else n_pass++;
    step();
    n_checks++; if (active !== 1'b0)   $display("FAIL dmr_active_idle got=%b exp=0 (c=%0d)", active, cyc - c0); else n_pass++;
    n_checks++; if (pdm !== 1'b0)      $display("FAIL dmr_pdm_idle got=%b exp=0", pdm); else n_pass++;
    n_checks++; if (underrun !== 1'b0) $display("FAIL dmr_underrun_idle got=%b exp=0", underrun); else n_pass++;
    en = 1'b1;
    #1;
    n_checks++; if (tready !== 1'b1) $display("FAIL dmr_flushed_tready got=%b exp=1", tready); else n_pass++;
    step();
    n_checks++; if (active !== 1'b0) $display("FAIL dmr_wait_active got=%b exp=0", active); else n_pass++;
    m_acc = 0;
    exp_q.delete();
    tvalid = 1'b1;
    tdata  = 18'h00000;
    hs = cyc;
    push_bits(hs + 3, 1, 18'h00000, 4, 4, 1'b1);
    step();
    tvalid  = 1'b0;
    cur_pdm = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front(); cur_pdm = e.pdm; cur_und = e.und;
      end else cur_und = 1'b0;
      n_checks++; if (pdm !== cur_pdm)      $display("FAIL dmr_restart_pdm cyc=%0d got=%b exp=%b", cyc - hs, pdm, cur_pdm); else n_pass++;
      n_checks++; if (underrun !== cur_und) $display("FAIL dmr_restart_underrun cyc=%0d got=%b exp=%b", cyc - hs, underrun, cur_und); else n_pass++;
      if (exp_q.size() == 0) break;
      step();
    end
    n_checks++; if (exp_q.size() != 0) $display("FAIL dmr_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_disabled();
    test_alternate();
    test_stream();
    test_divider();
    test_underrun();
    test_disable_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wfg_drive_pdm.md
Name: wfg_drive_pdm

Overview:
- AXI-Stream sink: the consuming end of the 18-bit signed sample stream produced by the stimulus generators.
- Accepts samples through a one-entry prefetch buffer and converts each one to a 1-bit pulse-density output using a first-order sigma-delta modulator.
- Bit rate is set by a clock divider; bits per sample (oversampling ratio) are configurable.
- Sits between a wfg_stim_* source and a pin; configured from register-file outputs.

Parameters:
- DIVW, 16, width of clock-divider config.
- OSRW, 8, width of oversampling-ratio config.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- wfg_drive_pdm_tready_o  output  1  AXI-Stream ready
- wfg_drive_pdm_tvalid_i  input  1  AXI-Stream valid
- wfg_drive_pdm_tdata_i  input  18  AXI-Stream signed sample
- ctrl_en_q_i  input  1  block enable
- clkcfg_div_q_i  input  DIVW  bit period minus 1, in clk cycles
- osr_q_i  input  OSRW  PDM bits per sample; 0 treated as 1
- pdm_o  output  1  registered PDM bit
- active_o  output  1  high while in RUN
- underrun_o  output  1  one-cycle pulse on sample underrun

Behaviour:
- Reset (async, rst_n=0): state IDLE; buffer empty; acc=0; div counter=0; bit counter=0; sample_q=0; pdm_o=0; active_o=0; underrun_o=0.
- tready = ctrl_en_q_i & !buf_full (combinational).
- Handshake: tvalid & tready captures tdata into buffer; buf_full=1 on the next cycle.
- Buffer entry: sample_u = tdata XOR 18'h20000, i.e. unsigned offset-binary equal to value + 2^17.
- States: IDLE, WAIT, RUN.
- IDLE: entered and held whenever ctrl_en_q_i=0; every state element cleared to its reset value on the next edge. Goes to WAIT when ctrl_en_q_i=1.
- WAIT: when buf_full, consume the buffer (sample_q <= buffer, buf_full <= 0, acc <= 0, counters <= 0) and go to RUN.
- RUN, divider: div counter increments every cycle; tick when cnt >= clkcfg_div_q_i, then cnt <= 0. With div=0, tick every cycle.
- RUN, modulator on tick: sum[18:0] = acc + sample_q; pdm_o <= sum[18]; acc <= sum[17:0].
- RUN, bit counter on tick: increments; sample boundary when bitcnt >= osr_eff-1 (osr_eff = max(osr_q_i,1)), then bitcnt <= 0.
- Sample boundary, buffer full: sample_q <= buffer, buf_full <= 0. A handshake in that same cycle is impossible because tready=0 while full.
- Sample boundary, buffer empty: underrun_o pulses for 1 cycle; sample_q is kept (repeated); acc continues.
- Latency: handshake at cycle 0 in WAIT → sample_q loaded at cycle 1 → RUN at cycle 2 → first tick at cycle 2+div → pdm_o updates at cycle 3+div.
- Steady-state consumption: one sample per osr_eff*(div+1) cycles.
- Config changes while running take effect immediately. The ">=" compares guarantee no counter wrap when a limit is lowered.
- Enable dropping mid-RUN: tready falls in the same cycle; next edge goes to IDLE with buffer flushed and pdm_o=0. Any sample held in the buffer is discarded.
- Output density: ones fraction = sample_u / 2^18. -131072 gives all zeros; 0 gives an alternating pattern.
- active_o = (state==RUN), registered.

Test Plan:
- Reset, then en=0 with tvalid=1 → tready=0, pdm_o=0, active_o=0, nothing consumed.
- en=1, div=0, osr=4, one sample 0 then no traffic → pdm_o sequence 0,1,0,1 starting cycle 3 after handshake. underrun_o pulses on the 4th tick, then pattern 0,1,0,1 repeats.
- div=0, osr=4, continuous samples 0x10000 then 0x20000 (-131072) → bits 0,1,1,1 then 0,0,0,0. Consecutive samples consumed exactly 4 cycles apart after the first; tready low while the buffer is full.
- div=3, osr=2, sample 0 → pdm_o changes only every 4th cycle. Next sample accepted 8 cycles after the previous consume.
- Underrun: single sample 0x1FFFF (+131071), osr=1, div=0, tvalid held low afterwards → underrun_o pulses every cycle after the first; pdm_o mostly 1.
- en deasserted mid-RUN with buffer full → tready=0 the same cycle; next cycle IDLE, pdm_o=0, active_o=0. Re-enable and send sample 0 → output restarts from acc=0 (first bit 0).
